// File: rtl/seg7_result_decoder.sv
// seg7_result_decoder: receive side of the ALU result bundle ({Ze,N,C,V}, 7-seg).
// Waits for the bundle to hold steady, decodes it to a signed 4-bit value,
// checks flag/pattern consistency and offers each new settled result once on
// a single-entry valid/ready port.
// Build option: define SEG_SYNC_EN to pass the inputs through a 2-flop
// synchronizer before the stability logic (adds 2 cycles of latency).
module seg7_result_decoder #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [6:0]        seg_in,
   input  logic [3:0]        flags_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic signed [3:0] out_value,
   output logic [3:0]        out_flags,
   output logic              out_err,
   output logic              overrun
);

   localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [0:0] {SETTLE, CAPTURE} state_t;

   state_t            state_p1, state_nxt;
   logic [10:0]       bundle_p0;
   logic [10:0]       prev_p1;
   logic              prev_vld_p1;
   logic [CNT_W-1:0]  cnt_p1, cnt_nxt;
   logic [10:0]       cap_p1;
   logic              cap_vld_p1;
   logic              changed, new_bundle, settle;
   logic [4:0]        dec_mag;
   logic signed [3:0] dec_value;
   logic              dec_err;
   logic              load_en, drop_en;

   // Magnitude lookup: {known, magnitude}; unknown patterns return known=0.
   function automatic logic [4:0] seg_to_mag(input logic [6:0] seg);
      case (seg)
         7'b0111111: seg_to_mag = {1'b1, 4'd0};
         7'b0000110: seg_to_mag = {1'b1, 4'd1};
         7'b1011011: seg_to_mag = {1'b1, 4'd2};
         7'b1001111: seg_to_mag = {1'b1, 4'd3};
         7'b1100110: seg_to_mag = {1'b1, 4'd4};
         7'b1101101: seg_to_mag = {1'b1, 4'd5};
         7'b1111100: seg_to_mag = {1'b1, 4'd6};
         7'b0000111: seg_to_mag = {1'b1, 4'd7};
         7'b1111111: seg_to_mag = {1'b1, 4'd8};
         default:    seg_to_mag = {1'b0, 4'd0};
      endcase
   endfunction

   // Apply the N flag: negative results wrap modulo 16 (magnitude 8 -> 4'b1000).
   function automatic logic signed [3:0] apply_sign(input logic [3:0] mag, input logic neg);
      apply_sign = neg ? $signed(4'd0 - mag) : $signed(mag);
   endfunction

`ifdef SEG_SYNC_EN
   logic [10:0] sync_p0;
   logic [10:0] sync_p1;

   // Two-flop synchronizer for inputs coming from another clock domain.
   always_ff @(posedge clk) begin
      sync_p0 <= {flags_in, seg_in};
      sync_p1 <= sync_p0;
   end

   assign bundle_p0 = sync_p1;
`else
   assign bundle_p0 = {flags_in, seg_in};
`endif

   // Stability tracking and settle detection; a settled bundle equal to the
   // last captured one is ignored.
   always_comb begin
      changed    = !prev_vld_p1 || (bundle_p0 != prev_p1);
      new_bundle = !cap_vld_p1 || (bundle_p0 != cap_p1);
      if (changed)
         cnt_nxt = CNT_ONE;
      else if (cnt_p1 == STABLE_C)
         cnt_nxt = cnt_p1;
      else
         cnt_nxt = cnt_p1 + CNT_ONE;
      settle = (cnt_nxt == STABLE_C) && (changed || (cnt_p1 != STABLE_C)) && new_bundle;
   end

   // Sample history, counter and last-captured bundle.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_vld_p1 <= 1'b0;
         cap_vld_p1  <= 1'b0;
         cnt_p1      <= '0;
      end else begin
         prev_vld_p1 <= 1'b1;
         cnt_p1      <= cnt_nxt;
         if (settle)
            cap_vld_p1 <= 1'b1;
      end
      prev_p1 <= bundle_p0;
      if (settle)
         cap_p1 <= bundle_p0;
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset)
         state_p1 <= SETTLE;
      else
         state_p1 <= state_nxt;
   end

   // FSM next state plus decode/consistency check of the captured bundle.
   always_comb begin
      state_nxt = SETTLE;
      load_en   = 1'b0;
      drop_en   = 1'b0;
      dec_mag   = seg_to_mag(cap_p1[6:0]);
      dec_value = 4'sd0;
      dec_err   = 1'b0;
      if (settle)
         state_nxt = CAPTURE;
      if (dec_mag[4])
         dec_value = apply_sign(dec_mag[3:0], cap_p1[9]);
      else
         dec_err = 1'b1;
      if (dec_mag[4] && (dec_mag[3:0] == 4'd0) && cap_p1[9])
         dec_err = 1'b1;
      if (dec_mag[4] && (dec_mag[3:0] == 4'd8) && !cap_p1[9])
         dec_err = 1'b1;
      if (cap_p1[10] != (dec_value == 4'sd0))
         dec_err = 1'b1;
      if (state_p1 == CAPTURE) begin
         load_en = !out_valid || out_ready;
         drop_en = out_valid && !out_ready;
      end
   end

   // ---- output stage: single-entry valid/ready register ----
   // Load, drop (with sticky overrun) or hand-off of the output entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_value <= 4'sd0;
         out_flags <= 4'd0;
         out_err   <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (load_en) begin
            out_valid <= 1'b1;
            out_value <= dec_value;
            out_flags <= cap_p1[10:7];
            out_err   <= dec_err;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (drop_en)
            overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_seg7_result_decoder.sv
// Directed bench for seg7_result_decoder (default build, STABLE_CYCLES = 4).
module tb_seg7_result_decoder;

   logic              clk = 1'b0;
   logic              reset;
   logic [6:0]        seg_in;
   logic [3:0]        flags_in;
   logic              out_valid;
   logic              out_ready;
   logic signed [3:0] out_value;
   logic [3:0]        out_flags;
   logic              out_err;
   logic              overrun;

   int n_chk  = 0;
   int n_fail = 0;

   seg7_result_decoder #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .seg_in    (seg_in),
      .flags_in  (flags_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_value (out_value),
      .out_flags (out_flags),
      .out_err   (out_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic apply(input logic [6:0] seg, input logic [3:0] flg);
      seg_in   = seg;
      flags_in = flg;
   endtask

   // Compare {valid, value, flags, err, overrun} in one go.
   task automatic chk_out(input string tag, input logic ev, input logic [3:0] evalue,
                          input logic [3:0] eflags, input logic eerr, input logic eovr);
      logic [10:0] obs;
      logic [10:0] exp;
      obs = {out_valid, out_value, out_flags, out_err, overrun};
      exp = {ev, evalue, eflags, eerr, eovr};
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed v/val/flg/err/ovr=%b/%h/%b/%b/%b expected=%b/%h/%b/%b/%b",
                tag, obs[10], obs[9:6], obs[5:2], obs[1], obs[0],
                exp[10], exp[9:6], exp[5:2], exp[1], exp[0]);
      end
   endtask

   task automatic chk_valid(input string tag, input logic ev);
      n_chk++;
      assert (out_valid === ev) else begin
         n_fail++;
         $error("FAIL %s observed out_valid=%b expected=%b", tag, out_valid, ev);
      end
   endtask

   // New bundle applied just after an edge: valid must appear after the 5th edge.
   task automatic settle_chk(input string tag, input logic [3:0] evalue,
                             input logic [3:0] eflags, input logic eerr, input logic eovr);
      tick(4);
      chk_valid({tag, "_early"}, 1'b0);
      tick(1);
      chk_out(tag, 1'b1, evalue, eflags, eerr, eovr);
   endtask

   initial begin
      reset     = 1'b1;
      out_ready = 1'b1;
      apply(7'b1011011, 4'b0000);
      tick(2);
      chk_out("reset_state", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);

      // Value 2, consumed immediately, valid for one cycle only.
      reset = 1'b0;
      settle_chk("val_2", 4'h2, 4'b0000, 1'b0, 1'b0);
      tick(1);
      chk_out("val_2_one_cycle", 1'b0, 4'h2, 4'b0000, 1'b0, 1'b0);

      // -8 is legal, +8 is flagged.
      apply(7'b1111111, 4'b0100);
      settle_chk("neg_8", 4'h8, 4'b0100, 1'b0, 1'b0);
      apply(7'b1111111, 4'b0000);
      settle_chk("pos_8_err", 4'h8, 4'b0000, 1'b1, 1'b0);

      // Zero cases and error classes.
      apply(7'b0111111, 4'b1000);
      settle_chk("zero_ok", 4'h0, 4'b1000, 1'b0, 1'b0);
      apply(7'b0000000, 4'b1000);
      settle_chk("unknown_pat", 4'h0, 4'b1000, 1'b1, 1'b0);
      apply(7'b0000110, 4'b1000);
      settle_chk("ze_mismatch", 4'h1, 4'b1000, 1'b1, 1'b0);
      apply(7'b0111111, 4'b1100);
      settle_chk("neg_zero", 4'h0, 4'b1100, 1'b1, 1'b0);
      apply(7'b1001111, 4'b0100);
      settle_chk("neg_3", 4'hD, 4'b0100, 1'b0, 1'b0);
      tick(1);

      // Back-pressure: 3 held, -5 dropped with overrun.
      out_ready = 1'b0;
      apply(7'b1001111, 4'b0000);
      settle_chk("hold_3", 4'h3, 4'b0000, 1'b0, 1'b0);
      apply(7'b1101101, 4'b0100);
      tick(5);
      chk_out("overrun_drop", 1'b1, 4'h3, 4'b0000, 1'b0, 1'b1);
      out_ready = 1'b1;
      tick(1);
      chk_out("accept_3", 1'b0, 4'h3, 4'b0000, 1'b0, 1'b1);
      tick(6);
      chk_out("no_late_neg5", 1'b0, 4'h3, 4'b0000, 1'b0, 1'b1);

      // Short glitch and return to the captured bundle give no event.
      apply(7'b1101101, 4'b0000);
      settle_chk("val_5", 4'h5, 4'b0000, 1'b0, 1'b1);
      tick(1);
      chk_out("val_5_taken", 1'b0, 4'h5, 4'b0000, 1'b0, 1'b1);
      apply(7'b0000110, 4'b0000);
      tick(2);
      apply(7'b1101101, 4'b0000);
      tick(8);
      chk_out("glitch_none", 1'b0, 4'h5, 4'b0000, 1'b0, 1'b1);

      // Reset with a pending output, then re-capture of the same bundle.
      out_ready = 1'b0;
      apply(7'b1001111, 4'b0000);
      settle_chk("pre_reset_3", 4'h3, 4'b0000, 1'b0, 1'b1);
      reset = 1'b1;
      tick(1);
      chk_out("mid_reset", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      reset = 1'b0;
      settle_chk("recapture_3", 4'h3, 4'b0000, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/seg7_result_decoder.md
Name: seg7_result_decoder

Overview:
- Receive side of the ALU result interface. Watches the 7-segment pattern and the {Ze,N,C,V} flag nibble that the ALU drives.
- Waits until the bundle is stable, decodes it back to a signed 4-bit result, and checks it for consistency.
- Presents each distinct stable result once on a valid/ready output port. Used by the on-chip self-check logic and by the scan/readback path.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples needed before a bundle counts as settled; legal range 1..255.
- CNT_W, 8, width of the stability counter; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- seg_in  input  7  segment pattern; bit 0 = segment 1 (top) ... bit 6 = segment 7 (middle); 1 = lit
- flags_in  input  4  {Ze,N,C,V}; bit 3 = Ze, bit 0 = V
- out_valid  output  1  decoded result available
- out_ready  input  1  consumer accepts the result when high with out_valid
- out_value  output  4  decoded signed two's-complement result
- out_flags  output  4  copy of the captured flags_in
- out_err  output  1  captured bundle was illegal or inconsistent
- overrun  output  1  sticky; a settled result was dropped because the output was full

Behaviour:
- Bundle = {flags_in, seg_in}, 11 bits. The stability counter restarts when the bundle differs from the previous sample. It increments while the bundle is unchanged and saturates.
- Settle event:
  - Fires for one cycle when the counter reaches STABLE_CYCLES.
  - Fires only if the bundle differs from the last captured bundle; the first settle after reset always counts.
  - Updates the last-captured register whether the result is accepted into the output or dropped.
- Latency: a bundle held constant from edge k (macro off) raises out_valid after edge k+STABLE_CYCLES.
- Magnitude decode of seg_in:
  - 0111111=0, 0000110=1, 1011011=2, 1001111=3, 1100110=4
  - 1101101=5, 1111100=6, 0000111=7, 1111111=8
  - Any other pattern is unknown.
- Value rule: N=0 gives out_value = magnitude; N=1 gives out_value = (-magnitude) mod 16, so magnitude 8 gives 4'b1000.
- out_err=1 on any of the following:
  - unknown pattern; out_value is then forced to 0
  - magnitude 0 with N=1
  - magnitude 8 with N=0
  - Ze != (out_value==0)
- Output register, single entry:
  - A settle event with out_valid=0, or with out_valid&out_ready in the same cycle, loads out_value/out_flags/out_err and sets out_valid=1.
  - A settle event with out_valid=1 and out_ready=0 drops the new result, sets overrun=1, and leaves the output unchanged.
  - out_valid&out_ready with no settle event clears out_valid; data outputs hold their last value.
  - While out_valid=1, outputs stay stable until accepted.
- A glitch shorter than STABLE_CYCLES produces no event. A bundle that returns to the last captured value produces no event.
- Reset, including mid-settle or with a pending output:
  - out_valid, out_value, out_flags, out_err and overrun go to 0.
  - The counter goes to 0 and the last-captured register is invalidated.
  - The first cycle after reset counts as a change.
- FSM:
  - SETTLE: counting; goes to CAPTURE on a settle event.
  - CAPTURE: single cycle; performs the load or drop, then returns to SETTLE.
  - A bundle change during CAPTURE restarts counting in SETTLE.

Optional Feature:
- Macro SEG_SYNC_EN.
- Defined: seg_in and flags_in pass through a 2-flop synchronizer before the stability logic. Latency grows by 2 cycles, to k+STABLE_CYCLES+2.
- Undefined: inputs go straight to the stability logic; the inputs are assumed synchronous to clk.

Test Plan:
- Reset, then hold seg_in=1011011, flags_in=0000, out_ready=1 -> out_valid high after edge STABLE_CYCLES (4), out_value=2, out_flags=0000, out_err=0, valid for 1 cycle only.
- seg_in=1111111, flags_in=0100 (N=1) held -> out_value=4'b1000, out_err=0. Then flags_in=0000 with the same pattern -> new event, out_value=8 mod 16, out_err=1.
- seg_in=0111111, flags_in=1000 held -> out_value=0, out_err=0. Then seg_in=0000000 -> out_value=0, out_err=1.
- out_ready=0; settle value 3 (1001111, flags 0000), then value -5 (1101101, flags 0100) -> output holds 3, overrun=1. Raise out_ready -> 3 accepted, no second event for -5.
- 2-cycle glitch to 0000110 inside a stable 5 pattern -> no event; out_valid stays 0 after the first capture.
- Assert reset while out_valid=1 -> all outputs 0 next cycle; same bundle held afterward -> re-captured after STABLE_CYCLES.
